// File: rtl/mips_loader_pkg.sv
// Shared opcodes and FSM encoding for the pipe_MIPS32 host loader.
package mips_loader_pkg;

  localparam logic [1:0] OP_MEM_WR = 2'd0;
  localparam logic [1:0] OP_MEM_RD = 2'd1;
  localparam logic [1:0] OP_REG_RD = 2'd2;
  localparam logic [1:0] OP_RUN    = 2'd3;

  // Primary opcode field of the core's HLT instruction.
  localparam logic [5:0] HLT_OPCODE = 6'h3f;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WRITE     = 3'd1,
    ST_RD_WAIT   = 3'd2,
    ST_RESP      = 3'd3,
    ST_RUN_START = 3'd4,
    ST_RUN       = 3'd5
  } loader_state_e;

endpackage

// File: rtl/mips_run_counter.sv
// Saturating run-cycle counter with synchronous clear and a limit compare.
module mips_run_counter #(
  parameter int W     = 16,
  parameter int LIMIT = 1000
) (
  input  logic         clk1,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         at_limit
);

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

  assign at_limit = (count == W'(LIMIT));

endmodule

// File: rtl/mips_prog_loader.sv
// Host loader/debug port for pipe_MIPS32: memory write/read, register read, run with cycle count.
// Optional RUN watchdog enabled by defining MIPS_LOADER_TIMEOUT_EN.
module mips_prog_loader
  import mips_loader_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int RUN_CNT_W = 16,
  parameter int TIMEOUT   = 1000
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              rsp_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [4:0]        reg_addr,
  input  logic [31:0]       reg_rdata,
  output logic              cpu_hold,
  output logic              pc_load,
  output logic [31:0]       pc_value,
  input  logic              cpu_halted,
  output logic [2:0]        dbg_state
);

  // Both channels: a transfer happens on a rising edge where valid && ready;
  // the sender holds its payload stable from asserting valid until that edge.

  loader_state_e        state;
  logic [1:0]           op_q;
  logic                 err_q;
  logic [RUN_CNT_W-1:0] cnt;
  logic                 cnt_at_limit;
  logic                 run_timeout;

  assign dbg_state = state;

  mips_run_counter #(
    .W     (RUN_CNT_W),
    .LIMIT (TIMEOUT)
  ) u_run_counter (
    .clk1     (clk1),
    .rst_n    (rst_n),
    .clr      (state == ST_RUN_START),
    .en       (state == ST_RUN),
    .count    (cnt),
    .at_limit (cnt_at_limit)
  );

`ifdef MIPS_LOADER_TIMEOUT_EN
  assign run_timeout = cnt_at_limit;
  assign rsp_err     = err_q;
`else
  logic unused_watchdog;
  assign unused_watchdog = cnt_at_limit ^ err_q;
  assign run_timeout     = 1'b0;
  assign rsp_err         = 1'b0;
`endif

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      op_q      <= OP_MEM_WR;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      err_q     <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      reg_addr  <= '0;
      cpu_hold  <= 1'b1;
      pc_load   <= 1'b0;
      pc_value  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            op_q      <= cmd_op;
            case (cmd_op)
              OP_MEM_WR: begin
                mem_addr  <= cmd_addr;
                mem_wdata <= cmd_data;
                mem_we    <= 1'b1;
                state     <= ST_WRITE;
              end
              OP_MEM_RD: begin
                mem_addr <= cmd_addr;
                state    <= ST_RD_WAIT;
              end
              OP_REG_RD: begin
                reg_addr <= cmd_addr[4:0];
                state    <= ST_RD_WAIT;
              end
              default: begin
                pc_value <= {{(32-ADDR_W){1'b0}}, cmd_addr};
                pc_load  <= 1'b1;
                cpu_hold <= 1'b0;
                state    <= ST_RUN_START;
              end
            endcase
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        ST_WRITE: begin
          mem_we    <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        ST_RD_WAIT: begin
          rsp_data  <= (op_q == OP_REG_RD) ? reg_rdata : mem_rdata;
          err_q     <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        // HALTED is not looked at here: it may still be left over from before the run.
        ST_RUN_START: begin
          pc_load <= 1'b0;
          state   <= ST_RUN;
        end
        ST_RUN: begin
          if (cpu_halted) begin
            cpu_hold  <= 1'b1;
            rsp_data  <= {{(32-RUN_CNT_W){1'b0}}, cnt};
            err_q     <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else if (run_timeout) begin
            cpu_hold  <= 1'b1;
            rsp_data  <= 32'(TIMEOUT);
            err_q     <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_prog_loader.sv
// Directed bench for mips_prog_loader with memory, register file and a tiny core model.
module tb_mips_prog_loader;
  import mips_loader_pkg::*;

`ifdef MIPS_LOADER_TIMEOUT_EN
  localparam int TB_TIMEOUT = 50;
`else
  localparam int TB_TIMEOUT = 1000;
`endif

  logic        clk1 = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [9:0]  cmd_addr = 10'd0;
  logic [31:0] cmd_data = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [4:0]  reg_addr;
  logic [31:0] reg_rdata;
  logic        cpu_hold;
  logic        pc_load;
  logic [31:0] pc_value;
  logic        cpu_halted = 1'b1;
  logic [2:0]  dbg_state;

  mips_prog_loader #(.ADDR_W(10), .RUN_CNT_W(16), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk1(clk1), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .reg_addr(reg_addr), .reg_rdata(reg_rdata), .cpu_hold(cpu_hold), .pc_load(pc_load),
    .pc_value(pc_value), .cpu_halted(cpu_halted), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk1 = ~clk1;
  int cyc = 0;
  always @(posedge clk1) cyc <= cyc + 1;

  // ---------------- environment: memory, register file, core ----------------
  logic [31:0] mem  [0:1023];
  logic [31:0] regs [0:31];
  logic [9:0]  cpu_pc = 10'd0;
  int          cpu_exec_cnt = 0;

  assign mem_rdata = mem[mem_addr];
  assign reg_rdata = regs[reg_addr];

  always @(posedge clk1) if (mem_we) mem[mem_addr] <= mem_wdata;

  // One instruction per cycle while released: ADD, OR, ADDI, BEQZ, HLT.
  always @(posedge clk1) begin
    logic [31:0] instr;
    instr = mem[cpu_pc];
    if (pc_load) begin
      cpu_pc       <= pc_value[9:0];
      cpu_halted   <= 1'b0;
      cpu_exec_cnt <= 0;
    end else if (cpu_hold) begin
      cpu_halted <= 1'b1;
    end else if (!cpu_halted) begin
      cpu_exec_cnt <= cpu_exec_cnt + 1;
      cpu_pc       <= cpu_pc + 10'd1;
      case (instr[31:26])
        6'h00: if (instr[15:11] != 5'd0) regs[instr[15:11]] <= regs[instr[25:21]] + regs[instr[20:16]];
        6'h03: if (instr[15:11] != 5'd0) regs[instr[15:11]] <= regs[instr[25:21]] | regs[instr[20:16]];
        6'h0a: if (instr[20:16] != 5'd0) regs[instr[20:16]] <= regs[instr[25:21]] + {{16{instr[15]}}, instr[15:0]};
        6'h0e: if (regs[instr[25:21]] == 32'd0) cpu_pc <= cpu_pc + 10'd1 + instr[9:0];
        HLT_OPCODE: cpu_halted <= 1'b1;
        default: ;
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [32:0] exp_q[$];
  logic [41:0] wr_q[$];
  logic [31:0] ref_mem [0:1023];
  int          hs_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic        prev_we = 1'b0, prev_rv = 1'b0, prev_hs = 1'b0, prev_err = 1'b0;
  logic [31:0] prev_data = 32'd0;

  always @(negedge clk1) begin
    logic [32:0] e;
    logic [41:0] w;
    if (!rst_n) begin
      prev_we = 1'b0; prev_rv = 1'b0; prev_hs = 1'b0;
    end else begin
      if (mem_we) begin
        chk("mem_we_pulse", 32'(prev_we), 32'd0);
        if (wr_q.size() == 0) chk("mem_we_unexpected", 32'd1, 32'd0);
        else begin
          w = wr_q.pop_front();
          chk("mem_addr", 32'(mem_addr), 32'(w[41:32]));
          chk("mem_wdata", mem_wdata, w[31:0]);
        end
      end
      if (rsp_valid && prev_rv && !prev_hs) begin
        chk("rsp_data_stable", rsp_data, prev_data);
        chk("rsp_err_stable", 32'(rsp_err), 32'(prev_err));
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("rsp_data", rsp_data, e[31:0]);
          chk("rsp_err", 32'(rsp_err), 32'(e[32]));
        end
      end
      if (rsp_valid || mem_we || cmd_ready) chk("cpu_hold_loader", 32'(cpu_hold), 32'd1);
      if (pc_load) chk("pc_load_released", 32'(cpu_hold), 32'd0);
      prev_we = mem_we; prev_rv = rsp_valid; prev_hs = rsp_valid && rsp_ready;
      prev_data = rsp_data; prev_err = rsp_err;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic [1:0] op, input logic [9:0] addr, input logic [31:0] data);
    bit done = 1'b0;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk1);
      if (cmd_ready) done = 1'b1;
    end
    if (!done) chk("cmd_accept_timeout", 32'd0, 32'd1);
    @(posedge clk1); #1;
    hs_cyc    = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_valid();
    bit seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk1);
      if (rsp_valid) seen = 1'b1;
    end
    if (!seen) chk("rsp_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic wr(input logic [9:0] addr, input logic [31:0] data);
    wr_q.push_back({addr, data});
    ref_mem[addr] = data;
    send_cmd(OP_MEM_WR, addr, data);
  endtask

  task automatic rd(input logic [1:0] op, input logic [9:0] addr, input logic [31:0] exp);
    exp_q.push_back({1'b0, exp});
    send_cmd(op, addr, 32'd0);
    wait_valid();
    @(posedge clk1); #1;
  endtask

  task automatic run_prog(input logic [9:0] addr, output logic [31:0] data, output logic err);
    rsp_ready = 1'b0;
    send_cmd(OP_RUN, addr, 32'd0);
    @(negedge clk1);
    chk("pc_load_pulse", 32'(pc_load), 32'd1);
    chk("pc_value", pc_value, 32'(addr));
    chk("cpu_hold_run_start", 32'(cpu_hold), 32'd0);
    @(negedge clk1);
    chk("pc_load_single", 32'(pc_load), 32'd0);
    chk("cpu_hold_running", 32'(cpu_hold), 32'd0);
    chk("cmd_ready_running", 32'(cmd_ready), 32'd0);
    wait_valid();
    data = rsp_data;
    err  = rsp_err;
    chk("cpu_hold_after_run", 32'(cpu_hold), 32'd1);
    // A halted core reports its executed-instruction count; otherwise only the watchdog can answer.
    if (cpu_halted) exp_q.push_back({1'b0, 32'(cpu_exec_cnt)});
    else exp_q.push_back({1'b1, 32'(TB_TIMEOUT)});
    @(posedge clk1); #1 rsp_ready = 1'b1;
    @(negedge clk1);
    @(posedge clk1); #1;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_data"}, rsp_data, 32'd0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
    chk({tag, "_pc_load"}, 32'(pc_load), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] prog [0:8];
  logic [31:0] run_data;
  logic        run_err;
  int          last_hs;

  initial begin
    for (int i = 0; i < 1024; i++) begin mem[i] = 32'd0; ref_mem[i] = 32'd0; end
    for (int i = 0; i < 32; i++) regs[i] = 32'(i);
    prog[0] = 32'h2801000a; prog[1] = 32'h28020014; prog[2] = 32'h28030019;
    prog[3] = 32'h0ce73800; prog[4] = 32'h00222000; prog[5] = 32'h0ce73800;
    prog[6] = 32'h00832800; prog[7] = 32'h0ce73800; prog[8] = 32'hfc000000;

    repeat (3) @(posedge clk1);
    #1;
    check_reset_values("reset");
    chk("reset_mem_addr", 32'(mem_addr), 32'd0);
    chk("reset_mem_wdata", mem_wdata, 32'd0);
    chk("reset_reg_addr", 32'(reg_addr), 32'd0);
    chk("reset_pc_value", pc_value, 32'd0);
    chk("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk1); #2 rst_n = 1'b1;
    @(posedge clk1); #1;

    // Single write: one-cycle strobe, no response.
    wr(10'd0, 32'h2801000a);
    @(negedge clk1);
    chk("t1_mem_we", 32'(mem_we), 32'd1);
    chk("t1_mem_addr", 32'(mem_addr), 32'd0);
    chk("t1_mem_wdata", mem_wdata, 32'h2801000a);
    chk("t1_no_rsp", 32'(rsp_valid), 32'd0);
    @(negedge clk1);
    chk("t1_mem_we_low", 32'(mem_we), 32'd0);
    chk("t1_no_rsp_after", 32'(rsp_valid), 32'd0);
    @(posedge clk1); #1;

    // Write then read back.
    wr(10'd5, 32'h00222000);
    rd(OP_MEM_RD, 10'd5, 32'h00222000);

    // Register read with back-pressure; upper address bits must be ignored.
    rsp_ready = 1'b0;
    exp_q.push_back({1'b0, 32'd7});
    send_cmd(OP_REG_RD, 10'h3e7, 32'd0);
    wait_valid();
    for (int i = 0; i < 4; i++) begin
      chk("t3_cmd_ready_low", 32'(cmd_ready), 32'd0);
      chk("t3_rsp_data_held", rsp_data, 32'd7);
      if (i < 3) @(negedge clk1);
    end
    @(posedge clk1); #1 rsp_ready = 1'b1;
    @(negedge clk1);
    @(posedge clk1); #1;

    // Load the program back-to-back and run it.
    last_hs = 0;
    for (int i = 0; i < 9; i++) begin
      wr(10'(i), prog[i]);
      if (i > 0) chk("t4_write_rate", 32'(hs_cyc - last_hs), 32'd2);
      last_hs = hs_cyc;
    end
    run_prog(10'd0, run_data, run_err);
    chk("t4_run_count", run_data, 32'd9);
    chk("t4_run_err", 32'(run_err), 32'd0);
    rd(OP_REG_RD, 10'd4, 32'd30);
    rd(OP_REG_RD, 10'd5, 32'd55);
    rd(OP_REG_RD, 10'd7, 32'd7);
    rd(OP_MEM_RD, 10'd8, ref_mem[8]);

    // Self-loop at 100 (BEQZ R0,-1).
    wr(10'd100, 32'h3800ffff);
`ifdef MIPS_LOADER_TIMEOUT_EN
    run_prog(10'd100, run_data, run_err);
    chk("t5_timeout_data", run_data, 32'd50);
    chk("t5_timeout_err", 32'(run_err), 32'd1);
`endif

    // Reset during RUN.
    send_cmd(OP_RUN, 10'd100, 32'd0);
    repeat (10) @(negedge clk1);
    chk("t6_still_running", 32'(cpu_hold), 32'd0);
    #2 rst_n = 1'b0;
    #1 check_reset_values("t6_run_rst");
    @(negedge clk1); @(negedge clk1); #3 rst_n = 1'b1;
    @(posedge clk1); #1;
    rd(OP_MEM_RD, 10'd100, ref_mem[100]);

    // Reset during RESP: the pending response is dropped.
    rsp_ready = 1'b0;
    send_cmd(OP_MEM_RD, 10'd0, 32'd0);
    wait_valid();
    chk("t6_pending_data", rsp_data, 32'h2801000a);
    #2 rst_n = 1'b0;
    #1 check_reset_values("t6_resp_rst");
    @(negedge clk1); @(negedge clk1); #3 rst_n = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk1); #1;
    rd(OP_MEM_RD, 10'd4, ref_mem[4]);

    repeat (4) @(posedge clk1);
    chk("leftover_rsp_expect", 32'(exp_q.size()), 32'd0);
    chk("leftover_wr_expect", 32'(wr_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/mips_prog_loader.md
Name: mips_prog_loader

Overview:
- Host-side loader/debug port for pipe_MIPS32.
- Accepts commands over a valid/ready command channel to:
  - write words into the core's unified memory,
  - read words back from memory or the register file,
  - set PC and start execution.
- Returns results on a valid/ready response channel.
- Holds the core in HALTED state while loading. Releases it on RUN and reports a cycle count when the core executes HLT.

Parameters:
- ADDR_W, 10, memory word-address width (1024 words).
- RUN_CNT_W, 16, width of the run-cycle counter; saturates at all-ones.
- TIMEOUT, 1000, watchdog limit in clk1 cycles (used only with the optional feature).

Ports:
- clk1  in  1  single system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  loader accepts command this cycle.
- cmd_op  in  2  command opcode: 0 MEM_WR, 1 MEM_RD, 2 REG_RD, 3 RUN.
- cmd_addr  in  ADDR_W  memory word address, register index (low 5 bits), or start PC.
- cmd_data  in  32  write data for MEM_WR.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  host accepts response.
- rsp_data  out  32  read data, or run cycle count (zero-extended).
- rsp_err  out  1  set on RUN timeout; 0 otherwise.
- mem_we  out  1  memory write strobe, one cycle.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, valid one cycle after mem_addr is presented.
- reg_addr  out  5  register file read index.
- reg_rdata  in  32  register read data, valid one cycle after reg_addr is presented.
- cpu_hold  out  1  forces the core HALTED and TAKEN_BRANCH=0.
- pc_load  out  1  one-cycle strobe loading pc_value into PC.
- pc_value  out  32  start PC (zero-extended cmd_addr).
- cpu_halted  in  1  core's HALTED flag.

Behaviour:
- Reset values:
  - cmd_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0.
  - mem_we=0, mem_addr=0, mem_wdata=0, reg_addr=0.
  - cpu_hold=1, pc_load=0, pc_value=0.
  - FSM=IDLE, run counter=0.
- FSM states: IDLE, WRITE, RD_WAIT, RESP, RUN_START, RUN.
- IDLE:
  - cmd_ready=1. A handshake occurs when cmd_valid && cmd_ready.
  - MEM_WR → WRITE. MEM_RD/REG_RD → RD_WAIT. RUN → RUN_START.
  - Address, data and op are registered on the handshake.
- WRITE:
  - mem_we=1 for exactly one cycle with the registered addr/data.
  - Then → IDLE. No response is generated.
  - Back-to-back writes sustain 1 word per 2 cycles.
- RD_WAIT:
  - The address is driven on mem_addr or reg_addr for one cycle.
  - The next edge captures mem_rdata or reg_rdata into rsp_data → RESP.
- RESP:
  - rsp_valid=1. rsp_data/rsp_err are held stable until rsp_ready.
  - On handshake → IDLE.
  - cmd_ready=0 throughout RESP.
- RUN_START:
  - pc_load=1 and cpu_hold=0 in the same cycle.
  - Counter cleared to 0 → RUN.
- RUN:
  - cmd_ready=0. Counter increments every cycle, saturating.
  - When cpu_halted is sampled high: cpu_hold=1, rsp_data=count, rsp_err=0 → RESP.
  - cpu_halted is ignored in the RUN_START cycle itself, because HALTED may still be stale from before the run.
- Invalid or unused cmd_addr bits are ignored: REG_RD uses cmd_addr[4:0].
- Reset asserted mid-operation:
  - Immediately returns to IDLE with cpu_hold=1.
  - Any pending response is discarded.
  - No mem_we glitch, because mem_we is a registered output.
- cpu_hold is 1 in every state except RUN_START and RUN.

Optional Feature:
- Macro: MIPS_LOADER_TIMEOUT_EN.
- Defined:
  - In RUN, when the counter reaches TIMEOUT without cpu_halted: assert cpu_hold, rsp_err=1, rsp_data=TIMEOUT → RESP.
- Undefined:
  - No watchdog; RUN waits indefinitely for cpu_halted.
  - rsp_err is tied to 0.

Decomposition:
- Package mips_loader_pkg holds:
  - opcode constants OP_MEM_WR/OP_MEM_RD/OP_REG_RD/OP_RUN,
  - the FSM state encoding,
  - the HLT opcode 6'h3f for bench use.
- Sub-module mips_run_counter: saturating counter with clear and compare to TIMEOUT. It is natural to split; everything else stays in one module.

Test Plan:
1. Reset, then MEM_WR addr=0 data=32'h2801000a → mem_we high exactly one cycle, mem_addr=0, mem_wdata=32'h2801000a; no rsp_valid.
2. MEM_WR addr=5 data=32'h00222000, then MEM_RD addr=5 → rsp_valid with rsp_data=32'h00222000, rsp_err=0.
3. With the register model preset Rk=k, REG_RD addr=7 → rsp_data=7. Hold rsp_ready=0 for 4 cycles: rsp_data stable and cmd_ready=0 throughout.
4. Load the 9-word program (last word 32'hfc000000), RUN addr=0:
   - pc_load pulse with pc_value=0, cpu_hold deasserts.
   - On HALTED: RESP with nonzero count, rsp_err=0.
   - Subsequent REG_RD of R4/R5 returns 30/55.
5. With MIPS_LOADER_TIMEOUT_EN and TIMEOUT=50, RUN on a looping program → after 50 cycles cpu_hold=1, rsp_err=1, rsp_data=50.
6. Assert rst_n low during RUN and during RESP → outputs return to reset values immediately; the first command after release is accepted normally.
